// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
// in_ready and out_valid are decoded only from state flops, so no combinational path crosses the stage.
module pipe_stage_skid #(
    parameter int unsigned          WIDTH       = 32,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [CNT_W-1:0] r_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main;
    logic w_main_from_skid;
    logic w_load_skid;

    assign out_valid  = (r_state != EMPTY);
    assign in_ready   = (r_state != SKID);
    assign out_data   = r_main;
    assign stall_cnt  = r_cnt;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_load_main  = 1'b1;
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end else if (w_out_fire) begin
                    w_state_next = EMPTY;
                end else if (w_in_fire) begin
                    w_load_skid  = 1'b1;
                    w_state_next = SKID;
                end
            end
            SKID: begin
                if (w_out_fire) begin
                    w_main_from_skid = 1'b1;
                    w_state_next     = FULL;
                end
            end
            default: w_state_next = EMPTY;
        endcase
        // Flush only drops validity; data registers are left untouched.
        if (flush) begin
            w_state_next     = EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= RESET_VALUE;
        end else begin
            r_state <= w_state_next;
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (out_valid && !out_ready && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, hand-written corner
// sequences (stall counter, reset in SKID) and a randomized run against a reference queue.
module tb_pipe_stage_skid;

    localparam int unsigned          WIDTH = 32;
    localparam int unsigned          CNT_W = 4;
    localparam logic [WIDTH-1:0]     RV    = 32'hDEAD_BEEF;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_skid #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             fl;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             e_ov;
        logic             e_ir;
        logic [WIDTH-1:0] e_od;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [WIDTH-1:0] d,
                                input logic ordy, input logic e_ov, input logic e_ir,
                                input logic [WIDTH-1:0] e_od);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od;
        return v;
    endfunction

    logic [WIDTH-1:0] q[$];

    initial begin
        // stream 1..8 with out_ready high, then drain
        for (int i = 0; i < 8; i++) begin
            vecs[i] = mk(1'b0, 1'b1, 32'(i + 1), 1'b1, 1'b1, 1'b1, 32'(i + 1));
        end
        vecs[8]  = mk(0, 0, 32'h0,  1, 0, 1, 32'h8);
        // back-pressure: A, B into skid, C held upstream
        vecs[9]  = mk(0, 1, 32'hA,  1, 1, 1, 32'hA);
        vecs[10] = mk(0, 1, 32'hB,  0, 1, 0, 32'hA);
        vecs[11] = mk(0, 1, 32'hC,  0, 1, 0, 32'hA);
        vecs[12] = mk(0, 1, 32'hC,  1, 1, 1, 32'hB);
        vecs[13] = mk(0, 1, 32'hC,  1, 1, 1, 32'hC);
        vecs[14] = mk(0, 0, 32'h0,  1, 0, 1, 32'hC);
        // flush in FULL with simultaneous in-fire of 0x55
        vecs[15] = mk(0, 1, 32'h11, 0, 1, 1, 32'h11);
        vecs[16] = mk(1, 1, 32'h55, 0, 0, 1, 32'h11);
        vecs[17] = mk(0, 0, 32'h0,  1, 0, 1, 32'h11);
        // flush in SKID with in_valid high
        vecs[18] = mk(0, 1, 32'h21, 0, 1, 1, 32'h21);
        vecs[19] = mk(0, 1, 32'h22, 0, 1, 0, 32'h21);
        vecs[20] = mk(1, 1, 32'h23, 0, 0, 1, 32'h21);
        vecs[21] = mk(0, 0, 32'h0,  1, 0, 1, 32'h21);

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_data",  out_data,       RV);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            flush = vecs[i].fl; in_valid = vecs[i].iv;
            in_data = vecs[i].d; out_ready = vecs[i].ordy;
            step();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_out_data", i),  out_data,       vecs[i].e_od);
        end
        flush = 1'b0;

        // stall counter saturation and clear
        cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        step();
        chk("cnt_cleared", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b0; in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("cnt_stall%0d", k), 32'(stall_cnt), (k < 15) ? 32'(k) : 32'd15);
        end
        cnt_clr = 1'b1;
        step();
        chk("cnt_clr_pulse", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b0;
        step();
        chk("cnt_resume1", 32'(stall_cnt), 32'd1);
        step();
        chk("cnt_resume2", 32'(stall_cnt), 32'd2);

        // async reset while in SKID
        in_valid = 1'b1; in_data = 32'h88;
        step();
        chk("skid_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_skid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_skid_in_ready",  32'(in_ready),  32'd1);
        chk("rst_skid_out_data",  out_data,       RV);
        chk("rst_skid_stall_cnt", 32'(stall_cnt), 32'd0);
        #2 rst = 1'b0;

        // random traffic against a reference queue
        in_valid = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_output", out_data, 32'hFFFF_FFFF);
                end else begin
                    chk("rand_order", out_data, q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            @(posedge clk);
            #1;
            chk("rand_occupancy_le2", 32'(q.size() <= 2), 32'd1);
            chk("rand_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rand_in_ready",  32'(in_ready),  32'(q.size() < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, a synchronous flush and a saturating back-pressure counter. It replaces the fixed-field, always-enabled inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each stage's fields are concatenated onto `in_data`. The block lets a downstream stall propagate upstream without a combinational ready path, and lets hazard logic squash the stage.

## Interface
- `WIDTH`, default 32: payload width in bits; minimum 1.
- `RESET_VALUE`, default 0: `WIDTH`-bit value loaded into both data registers on reset.
- `CNT_W`, default 16: width of the stall counter.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous squash of all buffered entries.
- `in_valid` in 1: upstream has a payload.
- `in_ready` out 1: stage can accept; registered.
- `in_data` in `WIDTH`: upstream payload.
- `out_valid` out 1: stage holds a payload; registered.
- `out_ready` in 1: downstream accepts.
- `out_data` out `WIDTH`: payload presented downstream; driven directly from the main register.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.
- `stall_cnt` out `CNT_W`: cycles with `out_valid && !out_ready`; saturating.

## Operation
- Handshake definitions:
  - in-fire = `in_valid && in_ready`.
  - out-fire = `out_valid && out_ready`.
  - Payload transfers only on a fire.
  - Upstream holds `in_data` stable while `in_valid && !in_ready`.
- Storage: main register (`out_data`) and one skid register.
- States:
  - EMPTY: no entry valid.
  - FULL: main valid.
  - SKID: main and skid both valid.
- Output encoding: `out_valid = (state != EMPTY)`, `in_ready = (state != SKID)`. Both are decoded from state flops only, never from inputs.
- Transitions, with flush = 0:
  - EMPTY, in-fire: main <= `in_data`, go to FULL.
  - EMPTY, no fire: stay.
  - FULL, in-fire and out-fire: main <= `in_data`, stay FULL.
  - FULL, out-fire only: go to EMPTY.
  - FULL, in-fire only: skid <= `in_data`, go to SKID.
  - FULL, neither: hold.
  - SKID (`in_ready` = 0, no in-fire possible), out-fire: main <= skid, go to FULL.
  - SKID, no out-fire: hold.
- Flush = 1:
  - Next state is EMPTY regardless of fires.
  - An in-fire in the flush cycle completes from upstream's view, but its payload is discarded.
  - An out-fire in the flush cycle completes normally, since downstream sampled it.
  - Data registers keep their contents; only the valid state is cleared.
- `stall_cnt`:
  - If `cnt_clr` = 1, it becomes 0.
  - Otherwise it increments by 1 when `out_valid && !out_ready`, holding at 2^`CNT_W`−1.
  - `cnt_clr` wins over a simultaneous stall.
  - Flush does not affect the counter.
- Ordering is strict FIFO: the skid entry is always older than any later input.

## Timing
- Reset, asynchronous on `rst` high:
  - State = EMPTY, so `out_valid` = 0 and `in_ready` = 1.
  - Main and skid registers = `RESET_VALUE`, so `out_data` = `RESET_VALUE`.
  - `stall_cnt` = 0.
  - Asserting `rst` mid-transfer drops all entries immediately.
  - First in-fire is possible on the first rising edge after `rst` deasserts.
- Latency: in-fire at edge N makes `out_valid` high and `out_data` = payload after edge N, i.e. 1 cycle.
- Throughput: 1 payload per cycle while `out_ready` stays high.
- Back-pressure: when `out_ready` drops, exactly one extra payload is absorbed into the skid register. `in_ready` falls one cycle after `out_ready` falls.
- Recovery: after `out_ready` rises in SKID, `in_ready` rises the following cycle.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.

## Test plan
- Reset with `RESET_VALUE`=32'hDEAD_BEEF → `out_data`=32'hDEAD_BEEF, `out_valid`=0, `in_ready`=1, `stall_cnt`=0. Also assert `rst` while in SKID → outputs return to those values with no clock edge.
- Stream 0x1..0x8 back-to-back with `out_ready`=1 → `out_data` shows 0x1..0x8 on consecutive cycles, 1-cycle latency, `in_ready` stays 1.
- Stream 0xA, 0xB, 0xC with `out_ready`=0 from the cycle 0xA appears:
  - 0xB lands in skid; `in_ready`=0 the next cycle; 0xC is held upstream.
  - Raise `out_ready` → outputs are 0xA, 0xB, 0xC in order, none lost or duplicated.
- Flush in SKID with `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1. Flush in FULL with simultaneous in-fire of 0x55 → 0x55 is never output.
- `CNT_W`=4 with `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt` reaches 15 and holds. `cnt_clr` pulsed during the stall → `stall_cnt`=0 the next cycle, then resumes counting.
- Random `in_valid`/`out_ready` at 50% for 10k cycles against a reference queue:
  - Output sequence matches the input sequence.
  - Occupancy never exceeds 2.
  - `in_valid` is never dropped while `in_ready`=0.
